// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-access stage: word widths, RISC-V
// load/store funct3 encodings, FSM state encodings and a legality helper.
package mem_access_unit_pkg;

    localparam int WORD_DATA    = 32;
    localparam int WORD_ADDR    = 32;
    localparam int REGS_ADDR    = 5;
    localparam int RISCV_FUNCT3 = 3;

    // Load funct3 encodings; SB/SH/SW share the LB/LH/LW values.
    localparam logic [RISCV_FUNCT3-1:0] F3_LB  = 3'b000;
    localparam logic [RISCV_FUNCT3-1:0] F3_LH  = 3'b001;
    localparam logic [RISCV_FUNCT3-1:0] F3_LW  = 3'b010;
    localparam logic [RISCV_FUNCT3-1:0] F3_LBU = 3'b100;
    localparam logic [RISCV_FUNCT3-1:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        MEM_ST_IDLE = 2'd0,
        MEM_ST_REQ  = 2'd1,
        MEM_ST_RESP = 2'd2,
        MEM_ST_DONE = 2'd3
    } mem_state_e;

    // Stores only have the three signed encodings; loads add the unsigned pair.
    function automatic logic f3_legal(input logic we, input logic [RISCV_FUNCT3-1:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB, F3_LH, F3_LW: ok = 1'b1;
            F3_LBU, F3_LHU:      ok = ~we;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// mem_load_extend: picks the addressed byte/half out of a read word and
// sign- or zero-extends it according to the load funct3.
module mem_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [WORD_DATA-1:0]    rdata_i,
    input  logic [1:0]              addr_lo_i,
    input  logic [RISCV_FUNCT3-1:0] funct3_i,
    output logic [WORD_DATA-1:0]    data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension; pure function of the inputs.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        byte_sel = rdata_i[7:0];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o   = '0;
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data_o = rdata_i;
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage between EX/MEM and write-back. Accepts one
// load/store, runs a single-outstanding req/gnt/rvalid bus transaction,
// stalls upstream until it retires and pulses the load result.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned half/word
// accesses as errors instead of silently ignoring the low address bits.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    exmem2mem_valid_i,
    input  logic                    exmem2mem_mem_en_i,
    input  logic                    exmem2mem_we_i,
    input  logic                    exmem2mem_wb_en_i,
    input  logic [RISCV_FUNCT3-1:0] exmem2mem_funct3_i,
    input  logic [WORD_ADDR-1:0]    exmem2mem_addr_i,
    input  logic [WORD_DATA-1:0]    exmem2mem_data_i,
    input  logic [REGS_ADDR-1:0]    exmem2mem_rd_i,
    output logic                    mem2cu_stall_o,
    output logic                    mem2bus_req_o,
    output logic                    mem2bus_we_o,
    output logic [WORD_ADDR-1:0]    mem2bus_addr_o,
    output logic [WORD_DATA-1:0]    mem2bus_wdata_o,
    output logic [3:0]              mem2bus_wstrb_o,
    input  logic                    bus2mem_gnt_i,
    input  logic                    bus2mem_rvalid_i,
    input  logic [WORD_DATA-1:0]    bus2mem_rdata_i,
    output logic                    mem2wb_valid_o,
    output logic [REGS_ADDR-1:0]    mem2wb_rd_o,
    output logic [WORD_DATA-1:0]    mem2wb_data_o,
    output logic                    mem2cu_err_o
);

    mem_state_e                state_q, state_d;
    logic                      we_q, we_d;
    logic                      wb_en_q, wb_en_d;
    logic                      err_q, err_d;
    logic [RISCV_FUNCT3-1:0]   funct3_q, funct3_d;
    logic [WORD_ADDR-1:0]      addr_q, addr_d;
    logic [WORD_DATA-1:0]      wdata_q, wdata_d;
    logic [3:0]                wstrb_q, wstrb_d;
    logic [REGS_ADDR-1:0]      rd_q, rd_d;
    logic [WORD_DATA-1:0]      ld_data_q, ld_data_d;

    logic                      accept;
    logic                      acc_err;
    logic                      misaligned;
    logic [WORD_DATA-1:0]      st_wdata;
    logic [3:0]                st_wstrb;
    logic [WORD_DATA-1:0]      ext_data;

    assign accept = (state_q == MEM_ST_IDLE) & exmem2mem_valid_i & exmem2mem_mem_en_i;

    // Decode the incoming access: error flag and store lane placement.
    always_comb begin
        misaligned = 1'b0;
        st_wdata   = '0;
        st_wstrb   = 4'b0000;
`ifdef MEM_ALIGN_CHECK_EN
        case (exmem2mem_funct3_i[1:0])
            2'b01:   misaligned = exmem2mem_addr_i[0];
            2'b10:   misaligned = |exmem2mem_addr_i[1:0];
            default: misaligned = 1'b0;
        endcase
`endif
        acc_err = ~f3_legal(exmem2mem_we_i, exmem2mem_funct3_i) | misaligned;
        if (exmem2mem_we_i) begin
            case (exmem2mem_funct3_i[1:0])
                2'b00: begin
                    st_wdata = {4{exmem2mem_data_i[7:0]}};
                    st_wstrb = 4'b0001 << exmem2mem_addr_i[1:0];
                end
                2'b01: begin
                    st_wdata = {2{exmem2mem_data_i[15:0]}};
                    st_wstrb = 4'b0011 << {exmem2mem_addr_i[1], 1'b0};
                end
                default: begin
                    st_wdata = exmem2mem_data_i;
                    st_wstrb = 4'b1111;
                end
            endcase
        end
    end

    mem_load_extend u_load_extend (
        .rdata_i   (bus2mem_rdata_i),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (funct3_q),
        .data_o    (ext_data)
    );

    // Next-state and captured-access logic for the IDLE/REQ/RESP/DONE FSM.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        wb_en_d   = wb_en_q;
        err_d     = err_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rd_d      = rd_q;
        ld_data_d = ld_data_q;
        case (state_q)
            MEM_ST_IDLE: begin
                if (accept) begin
                    we_d     = exmem2mem_we_i;
                    wb_en_d  = exmem2mem_wb_en_i;
                    err_d    = acc_err;
                    funct3_d = exmem2mem_funct3_i;
                    addr_d   = exmem2mem_addr_i;
                    wdata_d  = st_wdata;
                    wstrb_d  = st_wstrb;
                    rd_d     = exmem2mem_rd_i;
                    state_d  = acc_err ? MEM_ST_DONE : MEM_ST_REQ;
                end
            end
            MEM_ST_REQ: begin
                if (bus2mem_gnt_i) begin
                    state_d = we_q ? MEM_ST_DONE : MEM_ST_RESP;
                end
            end
            MEM_ST_RESP: begin
                if (bus2mem_rvalid_i) begin
                    ld_data_d = ext_data;
                    state_d   = MEM_ST_DONE;
                end
            end
            default: begin
                state_d = MEM_ST_IDLE;
            end
        endcase
    end

    // State and captured-access registers; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data registers are reset too, since they drive ports that must read 0 in reset.
        if (!rst_n) begin
            state_q   <= MEM_ST_IDLE;
            we_q      <= 1'b0;
            wb_en_q   <= 1'b0;
            err_q     <= 1'b0;
            funct3_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rd_q      <= '0;
            ld_data_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q   <= state_d;
            we_q      <= we_d;
            wb_en_q   <= wb_en_d;
            err_q     <= err_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rd_q      <= rd_d;
            ld_data_q <= ld_data_d;
        end
    end

    // Stall covers the accept cycle and every busy state except DONE.
    assign mem2cu_stall_o  = ((state_q == MEM_ST_REQ) | (state_q == MEM_ST_RESP)) | accept;
    assign mem2bus_req_o   = (state_q == MEM_ST_REQ);
    assign mem2bus_we_o    = (state_q == MEM_ST_REQ) & we_q;
    assign mem2bus_addr_o  = {addr_q[WORD_ADDR-1:2], 2'b00};
    assign mem2bus_wdata_o = wdata_q;
    assign mem2bus_wstrb_o = (state_q == MEM_ST_REQ) ? wstrb_q : 4'b0000;

    assign mem2wb_valid_o  = (state_q == MEM_ST_DONE) & ~we_q & wb_en_q & ~err_q & (rd_q != '0);
    assign mem2wb_rd_o     = rd_q;
    assign mem2wb_data_o   = ld_data_q;
    assign mem2cu_err_o    = (state_q == MEM_ST_DONE) & err_q;

endmodule
